// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the unified-memory port
//               arbiter (FSM state encoding, grant owner encoding, the
//               full-word byte-enable used for instruction fetches).
// Revision    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  // Transfer sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Grant owner; the numeric value is what appears on the owner port
  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  // Fetches always read a whole word
  localparam logic [3:0] BE_ALL = 4'hF;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : arb_watchdog
// Description : Ack watchdog for the memory port arbiter. Counts cycles while
//               enabled and signals expiry on the TIMEOUT-th enabled cycle, so
//               a transfer can occupy at most TIMEOUT cycles before abort.
//               With TIMEOUT = 0 the counter is not built and o_expire is 0.
// Revision    : 1.0  initial release
//
// Ports
//   clk       in   clock
//   rst       in   synchronous active-high reset (counter -> 0)
//   i_clr     in   clear the counter (arbiter not in ISSUE)
//   i_en      in   count this cycle (arbiter in ISSUE)
//   o_expire  out  combinational: this is the last permitted cycle
// ============================================================================
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  generate
    if (TIMEOUT == 0) begin : g_off
      // Watchdog disabled: inputs are intentionally left unused.
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst, i_clr, i_en};
      assign o_expire = 1'b0;
    end else begin : g_on
      // Wide enough to hold TIMEOUT itself (value reached on the abort edge).
      localparam int             CW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
      localparam logic [CW-1:0]  C_LAST = CW'(TIMEOUT - 1);
      localparam logic [CW-1:0]  C_ONE  = CW'(1);

      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst || i_clr) begin
          r_cnt <= '0;
        end else if (i_en) begin
          r_cnt <= r_cnt + C_ONE;
        end
      end

      // r_cnt counts completed ISSUE cycles, so the current cycle is the
      // TIMEOUT-th one when r_cnt == TIMEOUT-1.
      assign o_expire = i_en && (r_cnt == C_LAST);
    end
  endgenerate

endmodule : arb_watchdog
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port unified memory between the RV32I
//               instruction-fetch requester (I) and load/store requester (D).
//               A 3-state FSM (IDLE -> ISSUE -> RESP) serialises transfers on
//               a req/ack memory bus, returns read data plus a one-cycle done
//               pulse to the granted requester, and aborts transfers whose
//               ack never arrives (sticky err, rdata forced to 0).
// Revision    : 1.0  initial release
//
// Build option
//   ARB_ROUND_ROBIN_EN  when defined, simultaneous requests are granted to
//                       the requester that did not own the previous transfer;
//                       when undefined, D always beats I.
//
// Parameters
//   WIDTH    address/data width
//   TIMEOUT  max ISSUE cycles without m_ack before abort; 0 = no watchdog
//
// Ports (all outputs registered)
//   clk, rst                 clock, synchronous active-high reset
//   i_req/i_addr             fetch request (held until i_done) and address
//   i_rdata/i_done           fetched word, one-cycle completion pulse
//   d_req/d_we/d_addr        data request, 1 = store, byte address
//   d_wdata/d_be             store data and byte enables
//   d_rdata/d_done           load data, one-cycle completion pulse
//   m_req/m_we/m_addr        memory request, write, address
//   m_wdata/m_be             memory write data, byte enables (F on fetch)
//   m_ack/m_rdata            memory completion, read data valid with ack
//   owner                    current/last grant, 0 = I, 1 = D
//   err                      sticky watchdog-abort flag
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  // instruction fetch side
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] i_rdata,
  output logic             i_done,
  // load/store side
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  input  logic [3:0]       d_be,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_done,
  // memory bus
  output logic             m_req,
  output logic             m_we,
  output logic [WIDTH-1:0] m_addr,
  output logic [WIDTH-1:0] m_wdata,
  output logic [3:0]       m_be,
  input  logic             m_ack,
  input  logic [WIDTH-1:0] m_rdata,
  // status
  output logic             owner,
  output logic             err
);

  state_t r_state;
  owner_t r_owner;

  logic w_grant_d;
  logic w_wd_en;
  logic w_wd_clr;
  logic w_expire;

  // --------------------------------------------------------------------------
  // Arbitration: decides who wins if a request is present in IDLE.
  // --------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
  // Alternate on contention; r_owner resets to I so D wins the first tie.
  assign w_grant_d = d_req && (!i_req || (r_owner == OWN_I));
`else
  // D belongs to the older instruction, so it always goes first.
  assign w_grant_d = d_req;
`endif

  // --------------------------------------------------------------------------
  // Watchdog: counts only while a transfer is outstanding on the bus.
  // --------------------------------------------------------------------------
  assign w_wd_en  = (r_state == ISSUE);
  assign w_wd_clr = (r_state != ISSUE);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expire (w_expire)
  );

  assign owner = r_owner;

  // --------------------------------------------------------------------------
  // Transfer FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= OWN_I;
      m_req   <= 1'b0;
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;
    end else begin
      // done is a pulse: only the ISSUE exit raises it, for the RESP cycle
      i_done <= 1'b0;
      d_done <= 1'b0;

      case (r_state)
        IDLE: begin
          if (i_req || d_req) begin
            // Requester fields are captured here and never resampled.
            m_req   <= 1'b1;
            r_state <= ISSUE;
            if (w_grant_d) begin
              r_owner <= OWN_D;
              m_we    <= d_we;
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_be    <= d_be;
            end else begin
              r_owner <= OWN_I;
              m_we    <= 1'b0;
              m_addr  <= i_addr;
              m_wdata <= '0;
              m_be    <= BE_ALL;
            end
          end
        end

        ISSUE: begin
          // An ack on the expiry cycle still counts as a normal completion.
          if (m_ack) begin
            m_req   <= 1'b0;
            r_state <= RESP;
            if (r_owner == OWN_D) begin
              d_done <= 1'b1;
              if (!m_we) begin
                d_rdata <= m_rdata;
              end
            end else begin
              i_done  <= 1'b1;
              i_rdata <= m_rdata;
            end
          end else if (w_expire) begin
            m_req   <= 1'b0;
            r_state <= RESP;
            err     <= 1'b1;
            if (r_owner == OWN_D) begin
              d_done  <= 1'b1;
              d_rdata <= '0;
            end else begin
              i_done  <= 1'b1;
              i_rdata <= '0;
            end
          end
        end

        RESP: begin
          // One dead cycle lets the requester drop req before re-arbitration.
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A vector table of
//               single transfers plus hand sequences for contention, slow
//               ack, stray ack, watchdog abort and reset mid-transfer. A
//               second instance with TIMEOUT = 4 exercises the watchdog.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_ack = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        owner, err;

  // watchdog instance (TIMEOUT = 4)
  logic        wd_d_req = 1'b0;
  logic [31:0] wd_d_addr = '0;
  logic [31:0] wd_i_rdata, wd_d_rdata;
  logic        wd_i_done, wd_d_done;
  logic        wd_m_req, wd_m_we;
  logic [31:0] wd_m_addr, wd_m_wdata;
  logic [3:0]  wd_m_be;
  logic        wd_m_ack = 1'b0;
  logic [31:0] wd_m_rdata = '0;
  logic        wd_owner, wd_err;

  mem_port_arbiter u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .owner(owner), .err(err)
  );

  mem_port_arbiter #(.WIDTH(32), .TIMEOUT(4)) u_dut_wd (
    .clk(clk), .rst(rst),
    .i_req(1'b0), .i_addr(32'h0), .i_rdata(wd_i_rdata), .i_done(wd_i_done),
    .d_req(wd_d_req), .d_we(1'b0), .d_addr(wd_d_addr), .d_wdata(32'h0), .d_be(4'hF),
    .d_rdata(wd_d_rdata), .d_done(wd_d_done),
    .m_req(wd_m_req), .m_we(wd_m_we), .m_addr(wd_m_addr), .m_wdata(wd_m_wdata), .m_be(wd_m_be),
    .m_ack(wd_m_ack), .m_rdata(wd_m_rdata),
    .owner(wd_owner), .err(wd_err)
  );

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] mem;
    int          delay;
  } vec_t;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // memory model controls
  bit          no_ack = 1'b0;
  bit          stray_ack = 1'b0;
  int          ack_delay = 0;
  logic [31:0] resp_data = '0;
  // reference rdata registers
  logic [31:0] mdl_i_rdata = '0;
  logic [31:0] mdl_d_rdata = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Memory responder: checks issued command against scoreboard head, checks
  // stability across ISSUE, and acks after ack_delay extra cycles.
  // --------------------------------------------------------------------------
  initial begin
    int          issue_cyc;
    logic        prev_req;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;
    issue_cyc = 0;
    prev_req  = 1'b0;
    cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
    forever begin
      @(negedge clk);
      if (m_req) begin
        if (!prev_req) begin
          issue_cyc = 0;
          cap_addr = m_addr; cap_wdata = m_wdata; cap_be = m_be; cap_we = m_we;
          if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL issue_unexpected: m_req raised with addr %h, none expected", m_addr);
          end else begin
            check("issue_we", {31'b0, m_we}, {31'b0, sb[0].we});
            check("issue_addr", m_addr, sb[0].addr);
            check("issue_be", {28'b0, m_be}, {28'b0, sb[0].be});
            if (sb[0].we) check("issue_wdata", m_wdata, sb[0].wdata);
          end
        end else begin
          issue_cyc++;
          check("stable_addr", m_addr, cap_addr);
          check("stable_wdata", m_wdata, cap_wdata);
          check("stable_be", {28'b0, m_be}, {28'b0, cap_be});
          check("stable_we", {31'b0, m_we}, {31'b0, cap_we});
        end
        m_ack   = !no_ack && (issue_cyc == ack_delay);
        m_rdata = m_ack ? resp_data : 32'h0BAD_F00D;
      end else begin
        m_ack   = stray_ack;
        m_rdata = 32'h0BAD_F00D;
      end
      prev_req = m_req;
    end
  end

  // --------------------------------------------------------------------------
  // Completion monitor: pops the scoreboard on every done pulse.
  // --------------------------------------------------------------------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (i_done || d_done)) begin
        if (i_done && d_done) begin
          n_cmp++; n_err++;
          $display("FAIL both_done: i_done and d_done high together, expected one");
        end
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: i_done=%0b d_done=%0b with no transfer pending", i_done, d_done);
        end else begin
          e = sb.pop_front();
          check("done_requester", {31'b0, d_done}, {31'b0, e.is_d});
          check("done_owner", {31'b0, owner}, {31'b0, e.is_d});
          check(e.is_d ? "d_rdata" : "i_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
        end
      end
    end
  end

  task automatic wait_done(input bit is_d, input int exp_lat, input string nm);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if ((is_d ? i_done : d_done) == 1'b1) begin
        n_cmp++; n_err++;
        $display("FAIL %s_other_done: other requester completed at edge %0d, expected none", nm, n);
      end
      seen = is_d ? d_done : i_done;
    end
    check({nm, "_seen"}, {31'b0, seen}, 32'd1);
    if (seen) check({nm, "_latency"}, n, exp_lat);
  endtask

  function automatic exp_t mk_exp(input vec_t v);
    exp_t e;
    e.is_d  = v.is_d;
    e.we    = v.is_d && v.we;
    e.addr  = v.addr;
    e.wdata = v.wdata;
    e.be    = v.is_d ? v.be : 4'hF;
    if (v.is_d) begin
      if (!v.we) mdl_d_rdata = v.mem;
      e.rdata = mdl_d_rdata;
    end else begin
      mdl_i_rdata = v.mem;
      e.rdata = mdl_i_rdata;
    end
    return e;
  endfunction

  task automatic drive(input vec_t v);
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    ack_delay = v.delay;
    resp_data = v.mem;
    sb.push_back(mk_exp(v));
    drive(v);
    wait_done(v.is_d, 2 + v.delay, nm);
    if (v.is_d) d_req = 1'b0; else i_req = 1'b0;
    @(posedge clk); #1;
  endtask

  // Both requesters raise req together; d_first selects expected order.
  task automatic pair(input bit d_first, input string nm);
    vec_t vd, vi;
    vd = '{is_d: 1'b1, we: 1'b1, addr: 32'h100, wdata: 32'hDEADBEEF, be: 4'b0011, mem: 32'h0, delay: 0};
    vi = '{is_d: 1'b0, we: 1'b0, addr: 32'h8, wdata: 32'h0, be: 4'h0, mem: 32'h00000013, delay: 0};
    @(negedge clk);
    ack_delay = 0;
    resp_data = vi.mem;
    if (d_first) begin
      sb.push_back(mk_exp(vd)); sb.push_back(mk_exp(vi));
    end else begin
      sb.push_back(mk_exp(vi)); sb.push_back(mk_exp(vd));
    end
    drive(vd);
    drive(vi);
    wait_done(d_first, 2, {nm, "_first"});
    if (d_first) d_req = 1'b0; else i_req = 1'b0;
    wait_done(!d_first, 3, {nm, "_second"});
    if (d_first) i_req = 1'b0; else d_req = 1'b0;
    @(posedge clk); #1;
  endtask

  vec_t vecs[6];

  initial begin
    int   n;
    int   n_iss;
    bit   seen;
    exp_t e;

    vecs[0] = '{is_d: 1'b0, we: 1'b0, addr: 32'h0,        wdata: 32'h0,        be: 4'h0,    mem: 32'h00500093, delay: 0};
    vecs[1] = '{is_d: 1'b1, we: 1'b0, addr: 32'h200,      wdata: 32'h0,        be: 4'hF,    mem: 32'h12345678, delay: 0};
    vecs[2] = '{is_d: 1'b1, we: 1'b1, addr: 32'h100,      wdata: 32'hDEADBEEF, be: 4'b0011, mem: 32'h0,        delay: 1};
    vecs[3] = '{is_d: 1'b0, we: 1'b0, addr: 32'h4,        wdata: 32'h0,        be: 4'h0,    mem: 32'h00A00113, delay: 2};
    vecs[4] = '{is_d: 1'b1, we: 1'b0, addr: 32'h104,      wdata: 32'h0,        be: 4'b0001, mem: 32'hCAFEF00D, delay: 3};
    vecs[5] = '{is_d: 1'b0, we: 1'b0, addr: 32'hFFFFFFFC, wdata: 32'h0,        be: 4'h0,    mem: 32'hFFFFFFFF, delay: 0};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_req", {31'b0, m_req}, 32'd0);
    check("rst_done", {30'b0, i_done, d_done}, 32'd0);
    check("rst_owner_err", {30'b0, owner, err}, 32'd0);
    check("rst_m_addr_be", m_addr | {28'b0, m_be}, 32'd0);
    check("rst_rdata", i_rdata | d_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---- single transfers from the table ----
    for (int k = 0; k < 6; k++) apply(vecs[k], $sformatf("vec%0d", k));

    // ---- contention: after a fetch both modes give D first ----
    pair(1'b1, "pair_after_i");
    // ---- contention after a D transfer: round robin hands I the grant ----
    apply(vecs[1], "pre_d");
    pair(!RR, "pair_after_d");

    // ---- slow ack with requester fields changing mid-transfer ----
    @(negedge clk);
    ack_delay = 5;
    resp_data = 32'h00112233;
    e = mk_exp('{is_d: 1'b0, we: 1'b0, addr: 32'h20, wdata: 32'h0, be: 4'h0, mem: 32'h00112233, delay: 5});
    sb.push_back(e);
    i_req = 1'b1; i_addr = 32'h20;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_addr = 32'hDEAD0000;
    wait_done(1'b0, 5, "slow_ack");
    i_req = 1'b0;
    @(posedge clk); #1;
    check("slow_ack_no_reissue", {31'b0, m_req}, 32'd0);
    ack_delay = 0;

    // ---- ack while idle is ignored ----
    stray_ack = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("stray_m_req", {31'b0, m_req}, 32'd0);
    check("stray_i_rdata", i_rdata, mdl_i_rdata);
    stray_ack = 1'b0;

    // ---- watchdog (TIMEOUT = 4) ----
    @(negedge clk);
    wd_d_req = 1'b1; wd_d_addr = 32'h40;
    n = 0;
    while (!wd_m_req && n < 10) begin @(posedge clk); #1; n++; end
    check("wd_issue_seen", {31'b0, wd_m_req}, 32'd1);
    wd_m_ack = 1'b1; wd_m_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    wd_m_ack = 1'b0; wd_d_req = 1'b0;
    check("wd_load_done", {31'b0, wd_d_done}, 32'd1);
    check("wd_load_rdata", wd_d_rdata, 32'h55AA55AA);
    check("wd_load_err", {31'b0, wd_err}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    wd_d_req = 1'b1; wd_d_addr = 32'h44;
    n_iss = 0; seen = 1'b0; n = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (wd_m_req) n_iss++;
      seen = wd_d_done;
    end
    wd_d_req = 1'b0;
    check("wd_abort_done", {31'b0, seen}, 32'd1);
    check("wd_issue_cycles", n_iss, 32'd4);
    check("wd_abort_m_req", {31'b0, wd_m_req}, 32'd0);
    check("wd_abort_rdata", wd_d_rdata, 32'd0);
    check("wd_abort_err", {31'b0, wd_err}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("wd_err_sticky", {31'b0, wd_err}, 32'd1);
    check("wd_no_extra_done", {31'b0, wd_d_done}, 32'd0);
    check("main_err_clear", {31'b0, err}, 32'd0);

    // ---- reset in ISSUE ----
    @(negedge clk);
    no_ack = 1'b1;
    e = mk_exp('{is_d: 1'b0, we: 1'b0, addr: 32'h300, wdata: 32'h0, be: 4'h0, mem: 32'h0, delay: 0});
    sb.push_back(e);
    i_req = 1'b1; i_addr = 32'h300;
    n = 0;
    while (!m_req && n < 10) begin @(posedge clk); #1; n++; end
    check("rst_issue_seen", {31'b0, m_req}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_m_req", {31'b0, m_req}, 32'd0);
    check("midrst_done", {30'b0, i_done, d_done}, 32'd0);
    check("midrst_err", {30'b0, err, wd_err}, 32'd0);
    check("midrst_rdata", i_rdata | d_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0; i_req = 1'b0; no_ack = 1'b0;
    sb.delete();
    mdl_i_rdata = '0; mdl_d_rdata = '0;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_idle", {29'b0, m_req, i_done, d_done}, 32'd0);
    apply(vecs[0], "post_rst_fetch");

    check("sb_drained", sb.size(), 32'd0);
    check("final_err", {31'b0, err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
